// File: rtl/clock_divider_multi_if.sv
// clock_divider_multi_if
// Divisor write bus for clock_divider_multi.
//   div_we   - one-cycle write strobe
//   div_sel  - channel addressed by the write
//   div_data - divisor value written into the addressed channel
// master: drives the bus (controller / testbench); slave: the divider.
interface clock_divider_multi_if #(
  parameter int SEL_WIDTH = 2,
  parameter int CNT_WIDTH = 32
);
  logic                 div_we;
  logic [SEL_WIDTH-1:0] div_sel;
  logic [CNT_WIDTH-1:0] div_data;

  modport master (output div_we, output div_sel, output div_data);
  modport slave  (input  div_we, input  div_sel, input  div_data);
endinterface

// File: rtl/clock_divider_multi.sv
// clock_divider_multi
// Multi-channel programmable clock divider. Each channel toggles clk_out
// every A+1 enabled input cycles and pulses tick for the cycle following
// each toggle. Divisor writes land in a pending register and are adopted
// only at a toggle, on disable or on sync, so no half-period is ever cut.
// Ports:
//   clk_in   - single clock for all channels
//   reset_n  - asynchronous active-low reset
//   enable   - per-channel run enable
//   sync     - synchronous phase restart of all channels
//   div_bus  - divisor write bus (div_we / div_sel / div_data)
//   clk_out  - registered divided clocks
//   tick     - one-cycle pulse per clk_out toggle
module clock_divider_multi #(
  parameter int CHANNELS    = 4,
  parameter int CNT_WIDTH   = 32,
  parameter int DEFAULT_DIV = 10,
  parameter int SEL_WIDTH   = 2
) (
  input  logic                    clk_in,
  input  logic                    reset_n,
  input  logic [CHANNELS-1:0]     enable,
  input  logic                    sync,
  clock_divider_multi_if.slave    div_bus,
  output logic [CHANNELS-1:0]     clk_out,
  output logic [CHANNELS-1:0]     tick
);

  logic [CNT_WIDTH-1:0] p_q [CHANNELS];
  logic [CNT_WIDTH-1:0] p_d [CHANNELS];
  logic [CNT_WIDTH-1:0] a_q [CHANNELS];
  logic [CNT_WIDTH-1:0] a_d [CHANNELS];
  logic [CNT_WIDTH-1:0] c_q [CHANNELS];
  logic [CNT_WIDTH-1:0] c_d [CHANNELS];
  logic [CHANNELS-1:0]  out_q, out_d;
  logic [CHANNELS-1:0]  tick_q, tick_d;

  always_comb begin
    out_d  = out_q;
    tick_d = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      p_d[i] = p_q[i];
      a_d[i] = a_q[i];
      c_d[i] = c_q[i];

      // Selects at or above CHANNELS never match any i, so they are dropped.
      if (div_bus.div_we && (div_bus.div_sel == SEL_WIDTH'(i)))
        p_d[i] = div_bus.div_data;

      if (sync || !enable[i]) begin
        // Idle/restart: adopt the pending divisor including a same-cycle write.
        c_d[i]    = '0;
        out_d[i]  = 1'b0;
        tick_d[i] = 1'b0;
        a_d[i]    = p_d[i];
      end else if (c_q[i] >= a_q[i]) begin
        // >= rather than == so a shrinking divisor can never strand C above A.
        c_d[i]    = '0;
        out_d[i]  = ~out_q[i];
        tick_d[i] = 1'b1;
        a_d[i]    = p_q[i];
      end else begin
        c_d[i]    = c_q[i] + CNT_WIDTH'(1);
        tick_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        p_q[i] <= CNT_WIDTH'(DEFAULT_DIV);
        a_q[i] <= CNT_WIDTH'(DEFAULT_DIV);
        c_q[i] <= '0;
      end
      out_q  <= '0;
      tick_q <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        p_q[i] <= p_d[i];
        a_q[i] <= a_d[i];
        c_q[i] <= c_d[i];
      end
      out_q  <= out_d;
      tick_q <= tick_d;
    end
  end

  assign clk_out = out_q;
  assign tick    = tick_q;

endmodule

// File: tb/tb_clock_divider_multi.sv
module tb_clock_divider_multi;

  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic       reset_n, rst_b_n;
  logic [3:0] enable;
  logic       sync;
  logic [3:0] clk_out, tick;
  logic [2:0] enable_b;
  logic       sync_b;
  logic [2:0] clk_out_b, tick_b;

  int n_tests = 0;
  int n_fail  = 0;

  clock_divider_multi_if #(.SEL_WIDTH(2), .CNT_WIDTH(32)) bus_a ();
  clock_divider_multi_if #(.SEL_WIDTH(2), .CNT_WIDTH(4))  bus_b ();

  clock_divider_multi #(.CHANNELS(4), .CNT_WIDTH(32), .DEFAULT_DIV(10), .SEL_WIDTH(2)) dut_a (
    .clk_in (clk_in), .reset_n (reset_n), .enable (enable), .sync (sync),
    .div_bus (bus_a), .clk_out (clk_out), .tick (tick)
  );

  clock_divider_multi #(.CHANNELS(3), .CNT_WIDTH(4), .DEFAULT_DIV(10), .SEL_WIDTH(2)) dut_b (
    .clk_in (clk_in), .reset_n (rst_b_n), .enable (enable_b), .sync (sync_b),
    .div_bus (bus_b), .clk_out (clk_out_b), .tick (tick_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic write_a(input logic [1:0] sel, input logic [31:0] data);
    bus_a.div_we = 1'b1; bus_a.div_sel = sel; bus_a.div_data = data;
    step();
    bus_a.div_we = 1'b0;
  endtask

  task automatic write_b(input logic [1:0] sel, input logic [3:0] data);
    bus_b.div_we = 1'b1; bus_b.div_sel = sel; bus_b.div_data = data;
    step();
    bus_b.div_we = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; rst_b_n = 1'b0;
    enable = 4'b0; sync = 1'b0; enable_b = 3'b0; sync_b = 1'b0;
    bus_a.div_we = 1'b0; bus_a.div_sel = 2'd0; bus_a.div_data = 32'd0;
    bus_b.div_we = 1'b0; bus_b.div_sel = 2'd0; bus_b.div_data = 4'd0;

    // Reset state
    #12;
    check("reset_clk_out", clk_out, 4'b0);
    check("reset_tick", tick, 4'b0);

    // Default divisor on ch0: toggle every 11 edges
    step();
    reset_n = 1'b1; rst_b_n = 1'b1; enable = 4'b0001;
    for (int n = 1; n <= 44; n++) begin
      step();
      check($sformatf("dflt_out_%0d", n), clk_out, {3'b0, 1'(((n / 11) % 2) == 1)});
      check($sformatf("dflt_tick_%0d", n), tick, {3'b0, 1'((n % 11) == 0)});
    end

    // ch1: divisor 10 -> 2 written at cycle 5 of the first half-period
    enable = 4'b0010;
    for (int m = 1; m <= 23; m++) begin
      if (m == 5) begin
        bus_a.div_we = 1'b1; bus_a.div_sel = 2'd1; bus_a.div_data = 32'd2;
      end
      step();
      bus_a.div_we = 1'b0;
      if (m == 1) check("ch0_off_after_disable", clk_out[0], 1'b0);
      if (m < 11) begin
        check($sformatf("chg_out_%0d", m), clk_out[1], 1'b0);
        check($sformatf("chg_tick_%0d", m), tick[1], 1'b0);
      end else begin
        check($sformatf("chg_out_%0d", m), clk_out[1], 1'((((m - 11) / 3) % 2) == 0));
        check($sformatf("chg_tick_%0d", m), tick[1], 1'(((m - 11) % 3) == 0));
      end
    end

    // ch2 with D=0: clk_in/2, tick every cycle
    enable = 4'b0000;
    write_a(2'd2, 32'd0);
    enable = 4'b0100;
    for (int m = 1; m <= 6; m++) begin
      step();
      if (m == 1) check("ch1_off", clk_out[1], 1'b0);
      check($sformatf("d0_out_%0d", m), clk_out[2], 1'((m % 2) == 1));
      check($sformatf("d0_tick_%0d", m), tick[2], 1'b1);
    end

    // Sync alignment: ch0/ch2 D=3 started 2 cycles apart
    enable = 4'b0000;
    write_a(2'd0, 32'd3);
    write_a(2'd2, 32'd3);
    enable = 4'b0001;
    step(); step();
    enable = 4'b0101;
    step(); step(); step();
    check("presync_ch0", clk_out[0], 1'b1);
    check("presync_ch2", clk_out[2], 1'b0);
    sync = 1'b1;
    step();
    sync = 1'b0;
    check("sync_clk_out", clk_out, 4'b0);
    check("sync_tick", tick, 4'b0);
    for (int m = 1; m <= 16; m++) begin
      step();
      check($sformatf("sync_out_%0d", m), {clk_out[2], clk_out[0]}, {2{1'(((m / 4) % 2) == 1)}});
      check($sformatf("sync_tick_%0d", m), {tick[2], tick[0]}, {2{1'((m % 4) == 0)}});
    end

    // Drop enable[3] mid-half-period
    enable = 4'b1000;
    for (int m = 1; m <= 15; m++) begin
      step();
      if (m == 11) begin
        check("en3_rise_out", clk_out[3], 1'b1);
        check("en3_rise_tick", tick[3], 1'b1);
      end
    end
    check("en3_mid_out", clk_out[3], 1'b1);
    check("en3_mid_tick", tick[3], 1'b0);
    enable = 4'b0000;
    step();
    check("en3_drop_out", clk_out[3], 1'b0);
    check("en3_drop_tick", tick[3], 1'b0);

    // Narrow counters: D=15 with CNT_WIDTH=4, half-period 16, no wrap
    write_b(2'd0, 4'd15);
    enable_b = 3'b001;
    for (int m = 1; m <= 32; m++) begin
      step();
      check($sformatf("max_out_%0d", m), clk_out_b[0], 1'(((m / 16) % 2) == 1));
      check($sformatf("max_tick_%0d", m), tick_b[0], 1'((m % 16) == 0));
    end

    // Out-of-range select on a 3-channel instance changes nothing
    enable_b = 3'b000;
    write_b(2'd3, 4'd1);
    enable_b = 3'b111;
    for (int m = 1; m <= 16; m++) begin
      step();
      check($sformatf("oor_out_%0d", m), clk_out_b,
            {1'(m >= 11), 1'(m >= 11), 1'(m >= 16)});
    end

    // Async reset mid-operation with all channels toggling
    write_a(2'd1, 32'd2);
    enable = 4'b1111;
    for (int m = 1; m <= 12; m++) step();
    check("pre_reset_tick2", tick[2], 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_clk_out", clk_out, 4'b0);
    check("async_rst_tick", tick, 4'b0);
    step();
    reset_n = 1'b1;
    for (int m = 1; m <= 11; m++) begin
      step();
      check($sformatf("post_rst_out_%0d", m), clk_out, (m == 11) ? 4'hF : 4'h0);
      check($sformatf("post_rst_tick_%0d", m), tick, (m == 11) ? 4'hF : 4'h0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
